// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC and FSM encodings.
package if_stage_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstAddrBus-1:0] DefaultResetPc = 32'h0000_0000;

  localparam logic [0:0] StFetch = 1'b0;
  localparam logic [0:0] StHold  = 1'b1;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction word cache: combinational lookup, single-word fill,
// valid bits cleared only by reset.
module if_icache
  import if_stage_pkg::*;
#(
  parameter int unsigned Lines = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [InstAddrBus-1:0] lookup_addr_i,
  output logic                   hit_o,
  output logic [InstBus-1:0]     data_o,
  input  logic                   fill_en_i,
  input  logic [InstAddrBus-1:0] fill_addr_i,
  input  logic [InstBus-1:0]     fill_data_i
);

  localparam int unsigned IdxW = $clog2(Lines);
  localparam int unsigned TagW = InstAddrBus - 2 - IdxW;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [InstBus-1:0] data_q [Lines];

  logic [IdxW-1:0] lookup_idx, fill_idx;
  logic [TagW-1:0] lookup_tag, fill_tag;
  logic            unused_lsb;

  assign lookup_idx = lookup_addr_i[2 +: IdxW];
  assign lookup_tag = lookup_addr_i[InstAddrBus-1 -: TagW];
  assign fill_idx   = fill_addr_i[2 +: IdxW];
  assign fill_tag   = fill_addr_i[InstAddrBus-1 -: TagW];
  assign unused_lsb = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

  assign hit_o  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign data_o = data_q[lookup_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: assembles 32-bit words from an 8-bit memory port into a one-entry
// output register. Define IF_ICACHE_EN to add a direct-mapped word cache (if_icache).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC     = DefaultResetPc,
  parameter int unsigned            ICACHE_LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   jump_en_i,
  input  logic [InstAddrBus-1:0] jump_addr_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  input  logic                   mem_rdy_i,
  input  logic [7:0]             mem_data_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o
);

  logic [0:0]             state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
  logic [InstBus-1:0]     buf_q, buf_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic                   valid_q, valid_d;

  logic               out_free, hit_take, beat, fill_en;
  logic [InstBus-1:0] word;
  logic               cache_hit;
  logic [InstBus-1:0] cache_data;

`ifdef IF_ICACHE_EN
  if_icache #(
    .Lines (ICACHE_LINES)
  ) u_icache (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_addr_i (fetch_pc_q),
    .hit_o         (cache_hit),
    .data_o        (cache_data),
    .fill_en_i     (fill_en),
    .fill_addr_i   (fetch_pc_q),
    .fill_data_i   (word)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Outputs read zero while reset is asserted, independent of the state registers.
  always_comb begin
    out_free   = !valid_q || !stall_i;
    hit_take   = (state_q == StFetch) && (cnt_q == 2'd0) && out_free && cache_hit;
    mem_req_o  = rst_n && (state_q == StFetch) && !hit_take;
    mem_addr_o = rst_n ? (fetch_pc_q + {30'd0, cnt_q}) : '0;
    beat       = mem_req_o && mem_rdy_i;
    word       = {mem_data_i, buf_q[23:0]};
    fill_en    = beat && (cnt_q == 2'd3) && !jump_en_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    buf_d      = buf_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;

    if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end

    if (jump_en_i) begin
      state_d    = StFetch;
      cnt_d      = 2'd0;
      fetch_pc_d = word_align(jump_addr_i);
      buf_d      = '0;
      valid_d    = 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (hit_take) begin
            pc_d       = fetch_pc_q;
            inst_d     = cache_data;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else if (beat) begin
            buf_d[8*cnt_q +: 8] = mem_data_i;
            cnt_d               = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (out_free) begin
                pc_d       = fetch_pc_q;
                inst_d     = word;
                valid_d    = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
              end else begin
                state_d = StHold;
              end
            end
          end
        end
        StHold: begin
          if (out_free) begin
            pc_d       = fetch_pc_q;
            inst_d     = buf_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      cnt_q      <= 2'd0;
      fetch_pc_q <= RESET_PC;
      buf_q      <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
      buf_q      <= buf_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed latency/stall/jump/reset scenarios, then a randomized run
// checked against an instruction-stream model of the fetch sequence.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  logic [7:0] mem [8192];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC     (32'h0000_0000),
    .ICACHE_LINES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdy_i    (mem_rdy_i),
    .mem_data_i   (mem_data_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  // Memory aliases every 8 KiB so any 32-bit address is backed.
  assign mem_data_i = mem[mem_addr_o[12:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[13'(a + 32'd3)], mem[13'(a + 32'd2)], mem[13'(a + 32'd1)], mem[13'(a)]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"}, mem_req_o, 0);
    check_eq({tag, "_addr"}, mem_addr_o, 0);
    check_eq({tag, "_pc"}, pc_o, 0);
    check_eq({tag, "_inst"}, inst_o, 0);
    check_eq({tag, "_vld"}, inst_valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        was_jump;
    int          idle;
    int          consumed;
    int          k;

    rst_n       = 1'b0;
    stall_i     = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = '0;
    mem_rdy_i   = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    repeat (2) @(negedge clk);
    check_reset("rst");

    // Back-to-back beats at 0..3, word visible after the 4th
    rst_n = 1'b1; mem_rdy_i = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_req", mem_req_o, 1);
      check_eq("t1_addr", mem_addr_o, i);
      check_eq("t1_vld_lo", inst_valid_o, 0);
      step();
    end
    check_eq("t1_vld", inst_valid_o, 1);
    check_eq("t1_pc", pc_o, 32'h0);
    check_eq("t1_inst", inst_o, 32'h0010_0513);

    // Stall holds output; next word fetched then held
    stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) check_eq("t2_addr", mem_addr_o, 32'd4 + i);
      step();
      check_eq("t2_pc_hold", pc_o, 32'h0);
      check_eq("t2_vld_hold", inst_valid_o, 1);
    end
    check_eq("t2_hold_req", mem_req_o, 0);
    stall_i = 1'b0;
    step();
    check_eq("t2_pc4", pc_o, 32'h4);
    check_eq("t2_inst4", inst_o, word_at(32'h4));
    check_eq("t2_vld4", inst_valid_o, 1);

    // Jump during the 3rd beat of the fetch at 8
    k = 0;
    while (mem_addr_o != 32'd10 && k < 20) begin
      step();
      k++;
    end
    check_eq("t3_reach", mem_addr_o, 32'd10);
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_1002;
    step();
    jump_en_i = 1'b0;
    check_eq("t3_vld_drop", inst_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_addr", mem_addr_o, 32'h1000 + i);
      step();
    end
    check_eq("t3_vld", inst_valid_o, 1);
    check_eq("t3_pc", pc_o, 32'h1000);
    check_eq("t3_inst", inst_o, word_at(32'h1000));

    // Ready toggling 1-0-1-0
    for (int i = 0; i < 7; i++) begin
      mem_rdy_i = (i % 2 == 0);
      step();
      if (i == 5) check_eq("t4_vld_lo", inst_valid_o, 0);
    end
    mem_rdy_i = 1'b1;
    check_eq("t4_vld", inst_valid_o, 1);
    check_eq("t4_pc", pc_o, 32'h1004);
    check_eq("t4_inst", inst_o, word_at(32'h1004));

    // Reset mid-fetch
    step(); step();
    rst_n = 1'b0; #1;
    check_reset("t5_mid");
    @(negedge clk);
    rst_n = 1'b1; #1;
    check_eq("t5_restart_req", mem_req_o, 1);
    check_eq("t5_restart_addr", mem_addr_o, 32'h0);
    repeat (4) step();
    check_eq("t5_pc", pc_o, 32'h0);
    check_eq("t5_inst", inst_o, 32'h0010_0513);

    // Reset while in HOLD
    stall_i = 1'b1;
    repeat (6) step();
    check_eq("t5_hold_req", mem_req_o, 0);
    check_eq("t5_hold_vld", inst_valid_o, 1);
    rst_n = 1'b0; #1;
    check_reset("t5_hold");
    @(negedge clk);
    rst_n = 1'b1; stall_i = 1'b0; #1;
    check_eq("t5_hold_restart", mem_addr_o, 32'h0);

`ifdef IF_ICACHE_EN
    // Loop to 0x40 twice: misses first, hits on the second pass
    jump_en_i = 1'b1; jump_addr_i = 32'h40;
    step();
    jump_en_i = 1'b0;
    check_eq("t6_miss_req", mem_req_o, 1);
    k = 0;
    while (!(inst_valid_o && pc_o == 32'h4C) && k < 40) begin
      step();
      k++;
    end
    check_eq("t6_first_pass", pc_o, 32'h4C);
    jump_en_i = 1'b1; jump_addr_i = 32'h40;
    step();
    jump_en_i = 1'b0; #1;
    check_eq("t6_hit_req", mem_req_o, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t6_vld", inst_valid_o, 1);
      check_eq("t6_pc", pc_o, 32'h40 + 4 * i);
      check_eq("t6_inst", inst_o, word_at(32'h40 + 4 * i));
      if (i < 3) check_eq("t6_req", mem_req_o, 0);
    end
`endif

    // Randomized run against the instruction-stream model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_pc   = 32'h0;
    idle     = 0;
    consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      stall_i   = ($urandom_range(0, 9) < 3);
      mem_rdy_i = ($urandom_range(0, 9) < 7);
      jump_en_i = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 2))
        0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       tgt = 32'($urandom_range(0, 8191));
        default: tgt = $urandom;
      endcase
      jump_addr_i = tgt;
      #1;
      if (inst_valid_o && !stall_i) begin
        check_eq("rnd_pc", pc_o, exp_pc);
        check_eq("rnd_inst", inst_o, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        check_eq("rnd_progress", idle, 0);
        break;
      end
      was_jump = jump_en_i;
      if (jump_en_i) exp_pc = tgt & 32'hFFFF_FFFC;
      step();
      jump_en_i = 1'b0;
      if (was_jump) check_eq("rnd_jump_drop", inst_valid_o, 0);
    end
    check_eq("rnd_consumed", (consumed > 300), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
